// File: rtl/operand_collect_queue_if.sv
// Handshake and bus bundle between dispatch, the CDB and the functional unit
// for the operand collection queue.
interface operand_collect_queue_if #(
    parameter int unsigned XLEN      = 32,
    parameter int unsigned NSRC      = 2,
    parameter int unsigned ROB_W     = 4,
    parameter int unsigned CDB_PORTS = 2,
    parameter int unsigned DEPTH     = 4,
    parameter int unsigned PAYLOAD_W = 16
);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic                      flush;
    logic                      disp_valid;
    logic                      disp_ready;
    logic [2*NSRC-1:0]         disp_sel;
    logic [XLEN-1:0]           disp_pc;
    logic [XLEN-1:0]           disp_imm;
    logic [PAYLOAD_W-1:0]      disp_payload;
    logic [NSRC-1:0]           rat_valid;
    logic [NSRC-1:0]           rob_ready;
    logic [NSRC*XLEN-1:0]      rat_value;
    logic [NSRC*XLEN-1:0]      rob_value;
    logic [NSRC*ROB_W-1:0]     rob_index;
    logic [CDB_PORTS-1:0]      cdb_valid;
    logic [CDB_PORTS*ROB_W-1:0] cdb_tag;
    logic [CDB_PORTS*XLEN-1:0] cdb_value;
    logic                      iss_valid;
    logic                      iss_ready;
    logic [NSRC*XLEN-1:0]      iss_op;
    logic [PAYLOAD_W-1:0]      iss_payload;
    logic [CNT_W-1:0]          count;

    modport master (
        output flush, disp_valid, disp_sel, disp_pc, disp_imm, disp_payload,
               rat_valid, rob_ready, rat_value, rob_value, rob_index,
               cdb_valid, cdb_tag, cdb_value, iss_ready,
        input  disp_ready, iss_valid, iss_op, iss_payload, count
    );

    modport slave (
        input  flush, disp_valid, disp_sel, disp_pc, disp_imm, disp_payload,
               rat_valid, rob_ready, rat_value, rob_value, rob_index,
               cdb_valid, cdb_tag, cdb_value, iss_ready,
        output disp_ready, iss_valid, iss_op, iss_payload, count
    );
endinterface

// File: rtl/operand_collect_queue.sv
// In-order operand collection queue: resolves source operands at dispatch,
// captures pending ones from the CDB and issues the head once complete.
module operand_collect_queue #(
    parameter int unsigned XLEN      = 32,
    parameter int unsigned NSRC      = 2,
    parameter int unsigned ROB_W     = 4,
    parameter int unsigned CDB_PORTS = 2,
    parameter int unsigned DEPTH     = 4,
    parameter int unsigned PAYLOAD_W = 16
) (
    input logic                    clk,
    input logic                    rst_n,
    operand_collect_queue_if.slave bus
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    logic [DEPTH-1:0]     valid_q;
    logic [PAYLOAD_W-1:0] payload_q [DEPTH];
    logic [NSRC-1:0]      rdy_q     [DEPTH];
    logic [ROB_W-1:0]     tag_q     [DEPTH][NSRC];
    logic [XLEN-1:0]      val_q     [DEPTH][NSRC];
    logic [PTR_W-1:0]     head_q;
    logic [PTR_W-1:0]     tail_q;
    logic [CNT_W-1:0]     count_q;

    logic                 disp_ready;
    logic                 disp_fire;
    logic                 iss_valid;
    logic                 iss_fire;
    logic [NSRC*XLEN-1:0] iss_op;

    logic [NSRC-1:0]      res_rdy;
    logic [ROB_W-1:0]     res_tag [NSRC];
    logic [XLEN-1:0]      res_val [NSRC];

    logic [NSRC-1:0]      wk_hit [DEPTH];
    logic [XLEN-1:0]      wk_val [DEPTH][NSRC];

    assign disp_ready = rst_n && (count_q < DEPTH_C);
    assign disp_fire  = bus.disp_valid && disp_ready && !bus.flush;
    assign iss_valid  = valid_q[head_q] && (&rdy_q[head_q]);
    // Flush wins over issue: a head presented during a flush is not consumed.
    assign iss_fire   = iss_valid && bus.iss_ready && !bus.flush;

    // Dispatch-time operand resolution.
    always_comb begin
        logic [1:0] sel;
        sel = 2'd0;
        for (int s = 0; s < NSRC; s++) begin
            sel        = bus.disp_sel[2*s +: 2];
            res_rdy[s] = 1'b1;
            res_tag[s] = bus.rob_index[s*ROB_W +: ROB_W];
            res_val[s] = '0;
            case (sel)
                2'd0: res_val[s] = bus.disp_pc;
                2'd2: res_val[s] = bus.disp_imm;
                2'd3: res_val[s] = '0;
                default: begin
                    if (bus.rat_valid[s]) begin
                        res_val[s] = bus.rat_value[s*XLEN +: XLEN];
                    end else if (bus.rob_ready[s]) begin
                        res_val[s] = bus.rob_value[s*XLEN +: XLEN];
                    end else begin
                        res_rdy[s] = 1'b0;
                        // Descending scan so the lowest matching port is applied last.
                        for (int p = CDB_PORTS - 1; p >= 0; p--) begin
                            if (bus.cdb_valid[p] &&
                                bus.cdb_tag[p*ROB_W +: ROB_W] == res_tag[s]) begin
                                res_rdy[s] = 1'b1;
                                res_val[s] = bus.cdb_value[p*XLEN +: XLEN];
                            end
                        end
                    end
                end
            endcase
        end
    end

    // CDB snoop for every stored operand, lowest port wins.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            for (int s = 0; s < NSRC; s++) begin
                wk_hit[i][s] = 1'b0;
                wk_val[i][s] = '0;
                for (int p = CDB_PORTS - 1; p >= 0; p--) begin
                    if (bus.cdb_valid[p] && bus.cdb_tag[p*ROB_W +: ROB_W] == tag_q[i][s]) begin
                        wk_hit[i][s] = 1'b1;
                        wk_val[i][s] = bus.cdb_value[p*XLEN +: XLEN];
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n || bus.flush) begin
            valid_q <= '0;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                rdy_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                for (int s = 0; s < NSRC; s++) begin
                    if (valid_q[i] && !rdy_q[i][s] && wk_hit[i][s]) begin
                        rdy_q[i][s] <= 1'b1;
                        val_q[i][s] <= wk_val[i][s];
                    end
                end
            end

            if (iss_fire) begin
                valid_q[head_q] <= 1'b0;
                head_q          <= head_q + 1'b1;
            end

            // Dispatch never targets a valid slot, so it cannot collide with wakeup.
            if (disp_fire) begin
                valid_q[tail_q]   <= 1'b1;
                payload_q[tail_q] <= bus.disp_payload;
                rdy_q[tail_q]     <= res_rdy;
                for (int s = 0; s < NSRC; s++) begin
                    tag_q[tail_q][s] <= res_tag[s];
                    val_q[tail_q][s] <= res_val[s];
                end
                tail_q <= tail_q + 1'b1;
            end

            case ({disp_fire, iss_fire})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    always_comb begin
        iss_op = '0;
        for (int s = 0; s < NSRC; s++) begin
            iss_op[s*XLEN +: XLEN] = val_q[head_q][s];
        end
    end

    assign bus.disp_ready  = disp_ready;
    assign bus.iss_valid   = iss_valid;
    assign bus.iss_op      = iss_op;
    assign bus.iss_payload = payload_q[head_q];
    assign bus.count       = count_q;

endmodule
